fwd_tag_pipe: RTL and testbench
===============================

// Module: fwd_tag_pipe
// PURPOSE
//  Producer side of the forwarding network: E->M and M->W pipeline registers plus
//  the write-back tag encoder. Decodes each instruction leaving E into a destination
//  register (A3) and a result source (Res), then carries A3/Res/AO/PC8/DR down to M and W.
//  Drives the A3_*, Res_*, AO_*, PC8_*, DR_WD inputs of the forwarding muxes (MFALUA/B,
//  MFCMP, MFRSD...) and the register-file write port.
// PARAMETERS
//  RES_NW  2'b00  no register write
//  RES_ALU 2'b01  result from ALU output (AO)
//  RES_DM  2'b10  result from data-memory read (DR)
//  RES_PC  2'b11  result is PC+8 (link)
// PORTS
//  clk      in   1   system clock, rising edge
//  reset    in   1   asynchronous, active-low reset
//  bubble_E in   1   E slot holds a stall bubble; M gets a NOP tag next edge
//  IR_E     in   32  instruction in E
//  PC8_E    in   32  PC+8 of instruction in E
//  AO_E     in   32  ALU result in E
//  RT_E     in   32  forwarded rt value in E (store data)
//  DR_M     in   32  data-memory read data in M
//  IR_M     out  32  instruction in M;  PC8_M out 32;  AO_M out 32;  RT_M out 32
//  A3_M     out  5   destination reg in M;  Res_M out 2  result source in M
//  Tnew_M   out  2   cycles until M result is ready (0 or 1)
//  IR_W     out  32  instruction in W;  PC8_W out 32;  AO_W out 32
//  DR_WD    out  32  registered memory data in W
//  A3_W     out  5   destination reg in W;  Res_W out 2  result source in W
//  WE_W     out  1   register-file write enable = (Res_W != RES_NW)
//  WD_W     out  32  write-back data: Res_W ALU->AO_W, DM->DR_WD, PC->PC8_W, NW->0
// BEHAVIOUR
//  - Async reset (reset==0): every registered output 0; Res_* = RES_NW; Tnew_M=0; WE_W=0.
//    Holds regardless of clk. First capture on the first rising edge after release.
//  - Each rising edge, M <= (bubble_E ? all-zero/NW : E inputs + encoded tag); W <= M
//    fields; DR_WD <= DR_M. No stall of M/W: both stages always advance. Latency 1/stage.
//  - Tag encoding of IR (op=[31:26], funct=[5:0], rt=[20:16], rd=[15:11]):
//    op 000000 with funct 100001 (addu) / 100011 (subu): A3=rd, Res=ALU
//    op 000000 with funct 001000 (jr):                   A3=0,  Res=NW
//    ori 001101, lui 001111:                             A3=rt, Res=ALU
//    lw 100011:                                          A3=rt, Res=DM
//    jal 000011:                                         A3=31, Res=PC
//    sw 101011, beq 000100, j 000010, nop, others:       A3=0,  Res=NW
//  - A3==0 always forces Res=NW ($0 is never a forwarding source).
//  - Tnew_M = 1 when M holds lw, else 0. W results are always ready.
//  - A3/Res of a stage change only at edges; outputs are glitch-free registered
//    values except WE_W/WD_W (combinational from W registers).
//  - bubble_E together with a valid IR_E: bubble wins; IR_E is dropped.
//  - Reset asserted mid-stream: all in-flight tags cleared at once, so no stale forward.
// STRUCTURE
//  - Shared package/header: RES_* codes, opcode/funct constants, M2E_/W2E_ select codes
//    (same header the forwarding muxes include).
//  - Sub-module res_encoder (combinational: IR -> A3, Res, Tnew). It is instantiated once
//    at the E output. Everything else is flat registers in this module.
// TESTING
//  1 reset=0 with random inputs toggling -> all outputs 0, Res_M=Res_W=00, WE_W=0.
//  2 addu $3,$1,$2, AO_E=0x1234 -> next edge A3_M=3, Res_M=01, AO_M=0x1234;
//    edge after: A3_W=3, WE_W=1, WD_W=0x1234.
//  3 lw $5,0($0), DR_M=0xCAFE -> edge 1: Res_M=10, Tnew_M=1;
//    edge 2: Res_W=10, DR_WD=0xCAFE, WD_W=0xCAFE.
//  4 jal, PC8_E=0x3008 -> A3_M=31, Res_M=11, PC8_M=0x3008; in W WD_W=0x3008.
//  5 addu $0,$1,$2 and sw -> Res_M=00, A3_M=0; bubble_E=1 with lw -> IR_M=0, Res_M=00.
//  6 back-to-back stream, reset pulsed low between edges -> M/W cleared immediately;
//    next instruction in E appears in M one edge after release.

Source files
------------

// File: rtl/fwd_tag_pipe_pkg.sv
// Shared definitions for the forwarding network: result-source codes, opcode and
// funct constants, and the forwarding-mux select codes consumed downstream.
package fwd_tag_pipe_pkg;

  typedef enum logic [1:0] {
    RES_NW  = 2'b00,
    RES_ALU = 2'b01,
    RES_DM  = 2'b10,
    RES_PC  = 2'b11
  } res_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Select codes for the consumer-side forwarding muxes (MFALUA/B, MFCMP, MFRSD).
  localparam logic [2:0] FWD_RF      = 3'd0;
  localparam logic [2:0] M2E_AO      = 3'd1;
  localparam logic [2:0] M2E_PC8     = 3'd2;
  localparam logic [2:0] W2E_WD      = 3'd3;
  localparam logic [2:0] M2D_AO      = 3'd4;
  localparam logic [2:0] M2D_PC8     = 3'd5;
  localparam logic [2:0] W2D_WD      = 3'd6;

endpackage

// File: rtl/fwd_tag_pipe_if.sv
// Bundle of E-stage inputs and M/W-stage outputs of the producer pipeline.
interface fwd_tag_pipe_if;
  import fwd_tag_pipe_pkg::*;

  logic        bubble_E;
  logic [31:0] IR_E;
  logic [31:0] PC8_E;
  logic [31:0] AO_E;
  logic [31:0] RT_E;
  logic [31:0] DR_M;

  logic [31:0] IR_M;
  logic [31:0] PC8_M;
  logic [31:0] AO_M;
  logic [31:0] RT_M;
  logic [4:0]  A3_M;
  res_t        Res_M;
  logic [1:0]  Tnew_M;

  logic [31:0] IR_W;
  logic [31:0] PC8_W;
  logic [31:0] AO_W;
  logic [31:0] DR_WD;
  logic [4:0]  A3_W;
  res_t        Res_W;
  logic        WE_W;
  logic [31:0] WD_W;

  modport master (
    output bubble_E, IR_E, PC8_E, AO_E, RT_E, DR_M,
    input  IR_M, PC8_M, AO_M, RT_M, A3_M, Res_M, Tnew_M,
    input  IR_W, PC8_W, AO_W, DR_WD, A3_W, Res_W, WE_W, WD_W
  );

  modport slave (
    input  bubble_E, IR_E, PC8_E, AO_E, RT_E, DR_M,
    output IR_M, PC8_M, AO_M, RT_M, A3_M, Res_M, Tnew_M,
    output IR_W, PC8_W, AO_W, DR_WD, A3_W, Res_W, WE_W, WD_W
  );

endinterface

// File: rtl/fwd_tag_pipe_res_encoder.sv
// Combinational tag encoder: instruction -> destination register, result source
// and cycles-until-ready as seen from the M stage.
module res_encoder
  import fwd_tag_pipe_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  a3,
  output res_t        res,
  output logic [1:0]  tnew
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] a3_raw;
  res_t       res_raw;

  assign op    = ir[31:26];
  assign funct = ir[5:0];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    a3_raw  = REG_ZERO;
    res_raw = RES_NW;
    tnew    = 2'd0;
    unique case (op)
      OP_SPECIAL: begin
        if (funct == FN_ADDU || funct == FN_SUBU) begin
          a3_raw  = rd;
          res_raw = RES_ALU;
        end
      end
      OP_ORI, OP_LUI: begin
        a3_raw  = rt;
        res_raw = RES_ALU;
      end
      OP_LW: begin
        a3_raw  = rt;
        res_raw = RES_DM;
        tnew    = 2'd1;
      end
      OP_JAL: begin
        a3_raw  = REG_RA;
        res_raw = RES_PC;
      end
      default: ;
    endcase
  end

  // $0 is never a forwarding source, so a zero destination carries no result.
  assign a3  = a3_raw;
  assign res = (a3_raw == REG_ZERO) ? RES_NW : res_raw;

endmodule

// File: rtl/fwd_tag_pipe.sv
// E->M and M->W pipeline registers carrying the write-back tag, plus the W-stage
// register-file write port.
module fwd_tag_pipe
  import fwd_tag_pipe_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  fwd_tag_pipe_if.slave  bus
);

  logic [4:0] a3_e;
  res_t       res_e;
  logic [1:0] tnew_e;

  res_encoder u_res_encoder (
    .ir   (bus.IR_E),
    .a3   (a3_e),
    .res  (res_e),
    .tnew (tnew_e)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values; the async reset clears all tags at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.IR_M   <= '0;
      bus.PC8_M  <= '0;
      bus.AO_M   <= '0;
      bus.RT_M   <= '0;
      bus.A3_M   <= REG_ZERO;
      bus.Res_M  <= RES_NW;
      bus.Tnew_M <= 2'd0;
      bus.IR_W   <= '0;
      bus.PC8_W  <= '0;
      bus.AO_W   <= '0;
      bus.DR_WD  <= '0;
      bus.A3_W   <= REG_ZERO;
      bus.Res_W  <= RES_NW;
    end else begin
      // A bubble overrides whatever sits on IR_E.
      if (bus.bubble_E) begin
        bus.IR_M   <= '0;
        bus.PC8_M  <= '0;
        bus.AO_M   <= '0;
        bus.RT_M   <= '0;
        bus.A3_M   <= REG_ZERO;
        bus.Res_M  <= RES_NW;
        bus.Tnew_M <= 2'd0;
      end else begin
        bus.IR_M   <= bus.IR_E;
        bus.PC8_M  <= bus.PC8_E;
        bus.AO_M   <= bus.AO_E;
        bus.RT_M   <= bus.RT_E;
        bus.A3_M   <= a3_e;
        bus.Res_M  <= res_e;
        bus.Tnew_M <= tnew_e;
      end
      bus.IR_W  <= bus.IR_M;
      bus.PC8_W <= bus.PC8_M;
      bus.AO_W  <= bus.AO_M;
      bus.DR_WD <= bus.DR_M;
      bus.A3_W  <= bus.A3_M;
      bus.Res_W <= bus.Res_M;
    end
  end

  assign bus.WE_W = (bus.Res_W != RES_NW);

  always_comb begin
    bus.WD_W = '0;
    unique case (bus.Res_W)
      RES_ALU: bus.WD_W = bus.AO_W;
      RES_DM:  bus.WD_W = bus.DR_WD;
      RES_PC:  bus.WD_W = bus.PC8_W;
      default: bus.WD_W = '0;
    endcase
  end

endmodule

// File: tb/tb_fwd_tag_pipe.sv
// Scoreboard bench for fwd_tag_pipe: the driver pushes the expected M/W contents for
// every issued slot, a monitor pops and compares one edge later.
module tb_fwd_tag_pipe;
  import fwd_tag_pipe_pkg::*;

  typedef struct {
    logic [31:0] ir_m, pc8_m, ao_m, rt_m;
    logic [4:0]  a3_m;
    logic [1:0]  res_m, tnew_m;
    logic [31:0] ir_w, pc8_w, ao_w, dr_wd, wd_w;
    logic [4:0]  a3_w;
    logic [1:0]  res_w;
    logic        we_w;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t q[$];
  exp_t prev;

  fwd_tag_pipe_if bus();

  fwd_tag_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference tag rules, written directly from the instruction-class table.
  function automatic void ref_tag(input logic [31:0] ir, output logic [4:0] a3,
                                  output logic [1:0] res, output logic [1:0] tnew);
    int op = int'(ir[31:26]);
    int fn = int'(ir[5:0]);
    a3 = 0; res = 0; tnew = 0;
    if (op == 0 && (fn == 'h21 || fn == 'h23)) begin a3 = ir[15:11]; res = 1; end
    else if (op == 'h0d || op == 'h0f)         begin a3 = ir[20:16]; res = 1; end
    else if (op == 'h23)                       begin a3 = ir[20:16]; res = 2; tnew = 1; end
    else if (op == 'h03)                       begin a3 = 31;        res = 3; end
    if (a3 == 0) res = 0;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  // Issue one E slot at the falling edge; the M/W state after the next rising edge is predicted.
  task automatic drive(input logic [31:0] ir, input logic [31:0] pc8, input logic [31:0] ao,
                       input logic [31:0] rt, input logic [31:0] dr, input logic bub);
    exp_t e;
    @(negedge clk);
    bus.IR_E = ir; bus.PC8_E = pc8; bus.AO_E = ao; bus.RT_E = rt;
    bus.DR_M = dr; bus.bubble_E = bub;
    e = zero_exp();
    if (!bub) begin
      e.ir_m = ir; e.pc8_m = pc8; e.ao_m = ao; e.rt_m = rt;
      ref_tag(ir, e.a3_m, e.res_m, e.tnew_m);
    end
    e.ir_w = prev.ir_m; e.pc8_w = prev.pc8_m; e.ao_w = prev.ao_m;
    e.a3_w = prev.a3_m; e.res_w = prev.res_m; e.dr_wd = dr;
    e.we_w = (prev.res_m != 0);
    case (prev.res_m)
      2'd1: e.wd_w = prev.ao_m;
      2'd2: e.wd_w = dr;
      2'd3: e.wd_w = prev.pc8_m;
      default: e.wd_w = 32'h0;
    endcase
    q.push_back(e);
    prev = e;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ir_m"},  bus.IR_M, 0);   check({tag, "_pc8_m"}, bus.PC8_M, 0);
    check({tag, "_ao_m"},  bus.AO_M, 0);   check({tag, "_rt_m"},  bus.RT_M, 0);
    check({tag, "_a3_m"},  32'(bus.A3_M), 0);  check({tag, "_res_m"}, 32'(bus.Res_M), 0);
    check({tag, "_tnew_m"}, 32'(bus.Tnew_M), 0);
    check({tag, "_ir_w"},  bus.IR_W, 0);   check({tag, "_pc8_w"}, bus.PC8_W, 0);
    check({tag, "_ao_w"},  bus.AO_W, 0);   check({tag, "_dr_wd"}, bus.DR_WD, 0);
    check({tag, "_a3_w"},  32'(bus.A3_W), 0);  check({tag, "_res_w"}, 32'(bus.Res_W), 0);
    check({tag, "_we_w"},  32'(bus.WE_W), 0);  check({tag, "_wd_w"},  bus.WD_W, 0);
  endtask

  function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs = 5'($urandom_range(0, 31));
    logic [4:0] rt = 5'($urandom_range(0, 31));
    logic [4:0] rd = 5'($urandom_range(0, 31));
    logic [15:0] imm = 16'($urandom);
    if ($urandom_range(0, 7) == 0) begin rt = 0; rd = 0; end
    case ($urandom_range(0, 11))
      0:  return r_type(6'h21, rs, rt, rd);
      1:  return r_type(6'h23, rs, rt, rd);
      2:  return r_type(6'h08, rs, 5'd0, 5'd0);
      3:  return i_type(6'h0d, rs, rt, imm);
      4:  return i_type(6'h0f, 5'd0, rt, imm);
      5:  return i_type(6'h23, rs, rt, imm);
      6:  return {6'h03, 26'($urandom)};
      7:  return i_type(6'h2b, rs, rt, imm);
      8:  return i_type(6'h04, rs, rt, imm);
      9:  return {6'h02, 26'($urandom)};
      10: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: one rising edge after each issued slot, compare the whole M/W picture.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ir_m", bus.IR_M, e.ir_m);        check("pc8_m", bus.PC8_M, e.pc8_m);
        check("ao_m", bus.AO_M, e.ao_m);        check("rt_m", bus.RT_M, e.rt_m);
        check("a3_m", 32'(bus.A3_M), 32'(e.a3_m));
        check("res_m", 32'(bus.Res_M), 32'(e.res_m));
        check("tnew_m", 32'(bus.Tnew_M), 32'(e.tnew_m));
        check("ir_w", bus.IR_W, e.ir_w);        check("pc8_w", bus.PC8_W, e.pc8_w);
        check("ao_w", bus.AO_W, e.ao_w);        check("dr_wd", bus.DR_WD, e.dr_wd);
        check("a3_w", 32'(bus.A3_W), 32'(e.a3_w));
        check("res_w", 32'(bus.Res_W), 32'(e.res_w));
        check("we_w", 32'(bus.WE_W), 32'(e.we_w));
        check("wd_w", bus.WD_W, e.wd_w);
      end
    end
  end

  initial begin
    prev = zero_exp();
    bus.bubble_E = 0; bus.IR_E = 0; bus.PC8_E = 0; bus.AO_E = 0; bus.RT_E = 0; bus.DR_M = 0;

    // Reset held low while inputs toggle and the clock runs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.IR_E = rand_instr(); bus.PC8_E = $urandom; bus.AO_E = $urandom;
      bus.RT_E = $urandom; bus.DR_M = $urandom; bus.bubble_E = 1'($urandom);
      @(posedge clk); #1;
      check_zero("rst");
    end
    @(negedge clk);
    reset = 1'b1;

    // Directed slots: addu, lw with memory data, jal, writes to $0, sw, bubble over lw.
    drive(r_type(6'h21, 5'd1, 5'd2, 5'd3), 32'h0000_3008, 32'h0000_1234, 32'h11, 32'h0, 1'b0);
    drive(i_type(6'h23, 5'd0, 5'd5, 16'h0), 32'h0000_300c, 32'h0000_0000, 32'h22, 32'h0, 1'b0);
    drive(i_type(6'h03, 5'd0, 5'd0, 16'h0c00), 32'h0000_3008, 32'h0000_0055, 32'h33, 32'h0000_cafe, 1'b0);
    drive(r_type(6'h21, 5'd1, 5'd2, 5'd0), 32'h0000_3010, 32'h0000_7777, 32'h44, 32'h0, 1'b0);
    drive(i_type(6'h2b, 5'd1, 5'd2, 16'h4), 32'h0000_3014, 32'h0000_0004, 32'h55, 32'h0, 1'b0);
    drive(i_type(6'h23, 5'd1, 5'd6, 16'h8), 32'h0000_3018, 32'h0000_0008, 32'h66, 32'h0, 1'b1);
    drive(i_type(6'h0f, 5'd0, 5'd7, 16'habcd), 32'h0000_301c, 32'habcd_0000, 32'h77, 32'hdead, 1'b0);

    // Randomized stream with occasional bubbles.
    for (int i = 0; i < 300; i++)
      drive(rand_instr(), $urandom, $urandom, $urandom, $urandom, ($urandom_range(0, 5) == 0));

    // Mid-stream reset pulse between edges, then resume.
    drive(i_type(6'h23, 5'd2, 5'd9, 16'h10), 32'h0000_4008, 32'h10, 32'h99, 32'h0, 1'b0);
    drive(i_type(6'h03, 5'd0, 5'd0, 16'h0), 32'h0000_400c, 32'h20, 32'h98, 32'hbeef, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_zero("mid_rst");
    prev = zero_exp();
    drive(r_type(6'h23, 5'd4, 5'd5, 5'd6), 32'h0000_5008, 32'h0000_0abc, 32'h12, 32'h0, 1'b0);
    #1 reset = 1'b1;
    for (int i = 0; i < 40; i++)
      drive(rand_instr(), $urandom, $urandom, $urandom, $urandom, ($urandom_range(0, 7) == 0));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
